// File: rtl/div_post.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_post                                                         |
// | Purpose  : Final stage of the iterative divider. Resolves the carry-save    |
// |            remainder and redundant quotient, corrects a negative remainder, |
// |            de-normalizes, sign-fixes, then offers one result to writeback.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module div_post #(
  parameter int XLEN    = 32,
  parameter int SHIFT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [XLEN-1:0]     r_i,
  input  logic [XLEN+1:0]     d_i,
  input  logic [2*XLEN+1:0]   r_1_i,
  input  logic [2*XLEN+1:0]   r_2_i,
  input  logic [XLEN-1:0]     pos_q_i,
  input  logic [XLEN-1:0]     neg_q_i,
  input  logic [SHIFT_W-1:0]  shift_i,
  input  logic                r_sign_i,
  input  logic                d_sign_i,
  input  logic                unsign_i,
  input  logic                rem_i,
  input  logic                div_zero_i,
  input  logic                overflow_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [XLEN-1:0]     result_o,
  input  logic                ready_i
);

  localparam int RW = 2*XLEN + 2;
  localparam int DW = XLEN + 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUM  = 3'd1,
    ST_CORR = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Captured operands
  logic [XLEN-1:0]    dvd_q;
  logic [DW-1:0]      div_q;
  logic [RW-1:0]      r1_q, r2_q;
  logic [XLEN-1:0]    pq_q, nq_q;
  logic [SHIFT_W-1:0] sh_q;
  logic               r_sign_q, d_sign_q, unsign_q, rem_sel_q, dz_q, ov_q;

  // Intermediate results
  logic [DW-1:0]      rn_q;
  logic [XLEN-1:0]    quo_q;
  logic [XLEN-1:0]    rem_mag_q;

  // SUM: only the upper DW bits of r1+r2 matter; the low half only supplies a carry.
  // Two XLEN-bit values overflow exactly when a > ~b.
  logic               lo_carry;
  logic [DW-1:0]      rn_sum;
  logic [XLEN-1:0]    q_diff;
  assign lo_carry = (r1_q[XLEN-1:0] > ~r2_q[XLEN-1:0]);
  assign rn_sum   = r1_q[RW-1:XLEN] + r2_q[RW-1:XLEN] + {{(DW-1){1'b0}}, lo_carry};
  assign q_diff   = pq_q - nq_q;

  // CORR: a negative partial remainder means the quotient overshot by one.
  logic [DW-1:0]      rn_fix;
  logic [XLEN-1:0]    q_fix;
  logic [XLEN-1:0]    rem_shift;
  assign rn_fix    = rn_q[DW-1] ? (rn_q + div_q) : rn_q;
  assign q_fix     = rn_q[DW-1] ? (quo_q - XLEN'(1)) : quo_q;
  assign rem_shift = XLEN'(rn_fix >> sh_q);

  // FIX: sign correction, then special-case overrides (div-by-zero wins).
  logic [XLEN-1:0]    q_sgn, rem_sgn, q_fin, rem_fin, result_nxt;
  assign q_sgn   = (!unsign_q && (r_sign_q ^ d_sign_q)) ? -quo_q : quo_q;
  assign rem_sgn = (!unsign_q && r_sign_q) ? -rem_mag_q : rem_mag_q;

  // Select overrides and the returned value
  always_comb begin
    q_fin   = q_sgn;
    rem_fin = rem_sgn;
    if (dz_q) begin
      q_fin   = '1;
      rem_fin = dvd_q;
    end else if (ov_q && !unsign_q) begin
      q_fin   = {1'b1, {(XLEN-1){1'b0}}};
      rem_fin = '0;
    end
    result_nxt = rem_sel_q ? rem_fin : q_fin;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b1;
    valid_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = ST_SUM;
      end
      ST_SUM:  state_nxt = ST_CORR;
      ST_CORR: state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers, each loaded only in the step that produces it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      div_q     <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      pq_q      <= '0;
      nq_q      <= '0;
      sh_q      <= '0;
      r_sign_q  <= 1'b0;
      d_sign_q  <= 1'b0;
      unsign_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
      rn_q      <= '0;
      quo_q     <= '0;
      rem_mag_q <= '0;
      result_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          dvd_q     <= r_i;
          div_q     <= d_i;
          r1_q      <= r_1_i;
          r2_q      <= r_2_i;
          pq_q      <= pos_q_i;
          nq_q      <= neg_q_i;
          sh_q      <= shift_i;
          r_sign_q  <= r_sign_i;
          d_sign_q  <= d_sign_i;
          unsign_q  <= unsign_i;
          rem_sel_q <= rem_i;
          dz_q      <= div_zero_i;
          ov_q      <= overflow_i;
        end
        ST_SUM: begin
          rn_q  <= rn_sum;
          quo_q <= q_diff;
        end
        ST_CORR: begin
          quo_q     <= q_fix;
          rem_mag_q <= rem_shift;
        end
        ST_FIX:  result_o <= result_nxt;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_post.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_div_post                                                      |
// | Purpose  : Directed self-checking bench for div_post.                       |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_div_post;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] r;
  logic [33:0] d;
  logic [65:0] r1, r2;
  logic [31:0] pq, nq;
  logic [4:0]  sh;
  logic        rs, ds, uns, rem, dz, ov;
  logic        busy, valid, ready;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  div_post #(.XLEN(32), .SHIFT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .r_i(r), .d_i(d), .r_1_i(r1), .r_2_i(r2),
    .pos_q_i(pq), .neg_q_i(nq), .shift_i(sh),
    .r_sign_i(rs), .d_sign_i(ds), .unsign_i(uns), .rem_i(rem),
    .div_zero_i(dz), .overflow_i(ov),
    .busy_o(busy), .valid_o(valid), .result_o(result), .ready_i(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream must never issue while the stage is occupied
  always @(posedge clk)
    if (rst_n) assert (!(start && busy)) else $error("start issued while busy");

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Load the basic operand set: Rn=1, Q=3, d=2, unsigned, no specials
  task automatic base_op();
    r = 32'h0; d = 34'd2; r1 = {34'd1, 32'd0}; r2 = 66'd0;
    pq = 32'd3; nq = 32'd0; sh = 5'd0;
    rs = 1'b0; ds = 1'b0; uns = 1'b1; rem = 1'b0; dz = 1'b0; ov = 1'b0;
  endtask

  // Issue one start, check 3-cycle latency and result; check release if ready is high
  task automatic run(input string tag, input logic [31:0] exp);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, ".valid_early"}, {31'd0, valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".valid"}, {31'd0, valid}, 32'd1);
    check({tag, ".result"}, result, exp);
    if (ready) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".released"}, {30'd0, busy, valid}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b1;
    base_op();
    #1;
    check("reset.busy",   {31'd0, busy},  32'd0);
    check("reset.valid",  {31'd0, valid}, 32'd0);
    check("reset.result", result,         32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic resolve
    base_op();            run("basic_q", 32'd3);
    base_op(); rem = 1;   run("basic_r", 32'd1);

    // Carry-save sum giving Rn=-1, corrected with d=2
    base_op(); r1 = {34'h3FFFFFFFE, 32'd0}; r2 = {34'd1, 32'd0}; pq = 32'd4;
    run("corr_q", 32'd3);
    rem = 1; run("corr_r", 32'd1);

    // Carry out of the low half, and a non-zero negative digit accumulator
    base_op(); r1 = {34'd0, 32'hFFFFFFFF}; r2 = {34'd0, 32'd1}; pq = 32'd10; nq = 32'd3;
    run("carry_q", 32'd7);
    rem = 1; run("carry_r", 32'd1);

    // De-normalize: Rn=8 >> 2
    base_op(); r1 = {34'd8, 32'd0}; sh = 5'd2; rem = 1;
    run("denorm_r", 32'd2);

    // Signed fix
    base_op(); uns = 0; rs = 1;          run("sgn_nq", 32'hFFFFFFFD);
    base_op(); uns = 0; rs = 1; rem = 1; run("sgn_nr", 32'hFFFFFFFF);
    base_op(); uns = 0; rs = 1; ds = 1;  run("sgn_bq", 32'd3);
    base_op(); uns = 0; rs = 1; ds = 1; rem = 1; run("sgn_br", 32'hFFFFFFFF);

    // Special cases
    base_op(); uns = 0; dz = 1; r = 32'h1234;          run("dz_q", 32'hFFFFFFFF);
    base_op(); uns = 0; dz = 1; r = 32'h1234; rem = 1; run("dz_r", 32'h1234);
    base_op(); uns = 0; ov = 1;                        run("ov_q", 32'h80000000);
    base_op(); uns = 0; ov = 1; rem = 1;               run("ov_r", 32'd0);
    base_op(); uns = 0; dz = 1; ov = 1; r = 32'h1234;  run("dzov_q", 32'hFFFFFFFF);
    base_op(); uns = 0; dz = 1; ov = 1; r = 32'h1234; rem = 1; run("dzov_r", 32'h1234);
    base_op(); ov = 1;                                 run("ov_uns_q", 32'd3);

    // Back-pressure: result held while ready is low
    base_op(); ready = 1'b0;
    run("hold", 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold.valid",  {31'd0, valid}, 32'd1);
      check("hold.busy",   {31'd0, busy},  32'd1);
      check("hold.result", result,         32'd3);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold.release", {30'd0, busy, valid}, 32'd0);
    check("hold.keep",    result,               32'd3);

    // Reset during CORR discards the operation
    base_op(); pq = 32'd9;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst.busy",   {31'd0, busy},  32'd0);
    check("rst.valid",  {31'd0, valid}, 32'd0);
    check("rst.result", result,         32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst.no_valid", {30'd0, busy, valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
